scp_port_bridge: RTL and testbench
==================================

Name: scp_port_bridge

Overview:
- Responder for the scp output port (and, optionally, its input port).
- Captures every byte the processor writes with OUT (outWrite/toOutputPort) into a small FIFO and drains it to an external sink over a valid/ready stream.
- The processor never stalls. Overflow is reported, never back-pressured.
- Sits between scp and the off-chip peripheral, e.g. a UART transmitter.

Parameters:
DATA_W, 8, port data width; matches scp toOutputPort/fromInputPort.
DEPTH, 8, FIFO entries; power of two, minimum 2.
CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
out_write  in  1  from scp outWrite; one push per clk edge while high.
out_data  in  DATA_W  from scp toOutputPort.
tx_valid  out  1  head entry available to sink.
tx_data  out  DATA_W  head entry.
tx_ready  in  1  sink accepts head when tx_valid & tx_ready.
ovf_clr  in  1  clears sticky overflow flag.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
count  out  CNT_W  current occupancy.
overflow  out  1  sticky: a push was dropped.
rx_valid  in  1  external byte offered (SCP_PORT_IN_LATCH_EN only).
rx_data  in  DATA_W  external byte.
rx_ready  out  1  bridge can take rx_data.
in_data  out  DATA_W  to scp fromInputPort.

Behaviour:
- Reset, asynchronous and immediate: wr_ptr=0, rd_ptr=0, count=0, tx_valid=0, overflow=0, full=0, empty=1, in_data=0, rx_ready=1. FIFO storage is not reset; tx_data is don't-care while tx_valid=0.
- push = out_write & (!full | pop).
- pop = tx_valid & tx_ready.
- Push latency: data written at edge N is visible on tx_data with tx_valid=1 after edge N. There is no combinational bypass.
- tx_valid = !empty, registered-equivalent (derived from count).
- tx_data = mem[rd_ptr], held stable while tx_valid & !tx_ready.
- Pointers are DEPTH-modulo and wrap silently.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full and out_write with no pop: byte dropped, no pointer change, overflow<=1 on that edge.
- Full and out_write with pop on the same edge: accepted, count stays DEPTH.
- Empty and tx_ready: no pop; pointers unchanged.
- overflow: set has priority over ovf_clr on the same edge; it is otherwise held until ovf_clr.
- Reset asserted mid-stream: all queued bytes are discarded; tx_valid drops asynchronously.
- Full output order is preserved. No duplication and no reordering under any tx_ready pattern.

Optional Feature:
Macro SCP_PORT_IN_LATCH_EN.
- Defined:
  - Input holding register: when rx_valid & rx_ready, in_data<=rx_data and rx_ready<=0.
  - rx_ready returns to 1 on the edge after in_data was latched, giving a one-deep, two-cycle accept rate.
  - in_data holds its last value, so an IN instruction always reads a stable byte.
- Undefined: in_data = rx_data combinationally, rx_ready tied 1, and no input flops.

Decomposition:
- Shared package scp_pkg: DATA_W=8 constant and a port_byte_t typedef (logic [7:0]). It is reused by scp and future memory-mapped peripherals.
- Natural sub-module scp_port_fifo: generic synchronous FIFO with DEPTH parameter, push/pop, full/empty/count.
- scp_port_bridge adds the drop/overflow policy and the optional input latch.

Test Plan:
- Reset, then out_write one cycle with out_data=8'h7B, tx_ready=0 -> next cycle tx_valid=1, tx_data=8'h7B, count=1; holds for 5 cycles.
- Push 8'h01..8'h08 on consecutive cycles, tx_ready=0 -> full=1, count=8. Then push 8'h09 -> dropped, overflow=1. Drain -> 01..08 in order, empty=1. ovf_clr -> overflow=0.
- Full FIFO, out_write with 8'hAA and tx_ready=1 on the same edge -> 8'h01 popped, 8'hAA accepted, count stays 8; 8'hAA is emitted last.
- Random tx_ready (50%) with a continuous push of an incrementing byte stream, 200 bytes -> sink receives an exact ordered sequence with no drops whenever average drain keeps up; scoreboard match.
- Assert rst asynchronously (not on a clock edge) with count=3 -> tx_valid=0, count=0, empty=1 immediately; subsequent push of 8'h55 appears as the sole entry.
- With SCP_PORT_IN_LATCH_EN: rx_valid=1, rx_data=8'hAA -> in_data=8'hAA after one edge, rx_ready=0 for one cycle. rx_data then changing to 8'h11 while rx_ready=0 -> in_data stays 8'hAA.

Source files
------------

// File: rtl/scp_pkg.sv
// scp_pkg: shared definitions for the scp processor and its port peripherals.
//   SCP_DATA_W  : width of an scp I/O port byte.
//   port_byte_t : one port byte.
package scp_pkg;
    localparam int SCP_DATA_W = 8;
    typedef logic [SCP_DATA_W-1:0] port_byte_t;
endpackage

// File: rtl/scp_port_fifo.sv
// scp_port_fifo: generic synchronous FIFO with occupancy count.
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   push, wr_data : write request and data
//   pop           : read request; rd_data shows the head entry
//   full, empty   : count == DEPTH / count == 0
//   count         : current occupancy
// Storage is not reset; only pointers and count are.
module scp_port_fifo
    import scp_pkg::*;
#(
    parameter int DATA_W = SCP_DATA_W,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];

    // Guard against callers popping empty or pushing full without a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are DEPTH-modulo: the truncating add wraps silently.
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/scp_port_bridge.sv
// scp_port_bridge: responder for the scp output port (and optionally input port).
// Every OUT byte is queued in a FIFO and drained over a valid/ready stream.
// The processor is never stalled: a byte written while full (and no pop on the
// same edge) is dropped and the sticky overflow flag is set.
//   clk, rst             : clock, asynchronous active-high reset
//   out_write, out_data  : scp outWrite / toOutputPort
//   tx_valid/data/ready  : stream to the external sink
//   ovf_clr, overflow    : clear / sticky dropped-byte flag
//   full, empty, count   : FIFO status
//   rx_valid/data/ready  : external byte source for the input port
//   in_data              : scp fromInputPort
// Build option SCP_PORT_IN_LATCH_EN: when defined, rx bytes are captured in a
// one-deep holding register (two-cycle accept rate); otherwise in_data follows
// rx_data combinationally and rx_ready is tied high.
module scp_port_bridge
    import scp_pkg::*;
#(
    parameter int DATA_W = SCP_DATA_W,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              out_write,
    input  logic [DATA_W-1:0] out_data,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    input  logic              ovf_clr,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_ready,
    output logic [DATA_W-1:0] in_data
);
    logic push, pop, drop;
    logic overflow_q, overflow_d;

    scp_port_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (out_data),
        .pop     (pop),
        .rd_data (tx_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // tx_valid derives from the registered count, so there is no
    // combinational path from out_write to the sink.
    assign tx_valid = ~empty;
    assign pop      = tx_valid & tx_ready;
    assign push     = out_write & (~full | pop);
    assign drop     = out_write & full & ~pop;
    assign overflow = overflow_q;

    always_comb begin
        overflow_d = overflow_q;
        // A drop on the same edge as ovf_clr must not be lost.
        if (drop)         overflow_d = 1'b1;
        else if (ovf_clr) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) overflow_q <= 1'b0;
        else     overflow_q <= overflow_d;
    end

`ifdef SCP_PORT_IN_LATCH_EN
    logic [DATA_W-1:0] in_data_q, in_data_d;
    logic              rx_ready_q, rx_ready_d;

    always_comb begin
        in_data_d  = in_data_q;
        rx_ready_d = 1'b1;
        if (rx_valid & rx_ready_q) begin
            in_data_d  = rx_data;
            rx_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_data_q  <= '0;
            rx_ready_q <= 1'b1;
        end else begin
            in_data_q  <= in_data_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    assign in_data  = in_data_q;
    assign rx_ready = rx_ready_q;
`else
    logic unused_rx_valid;
    assign unused_rx_valid = rx_valid;
    assign in_data         = rx_data;
    assign rx_ready        = 1'b1;
`endif
endmodule

// File: tb/tb_scp_port_bridge.sv
module tb_scp_port_bridge;
    import scp_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             out_write;
    port_byte_t       out_data;
    logic             tx_valid;
    port_byte_t       tx_data;
    logic             tx_ready;
    logic             ovf_clr;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             rx_valid;
    port_byte_t       rx_data;
    logic             rx_ready;
    port_byte_t       in_data;

    int n_cmp = 0;
    int n_err = 0;

    scp_port_bridge #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .out_write (out_write),
        .out_data  (out_data),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .ovf_clr   (ovf_clr),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .in_data   (in_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        port_byte_t d;
        logic       rdy;
        logic       clr;
        logic       vld;
        port_byte_t td;
        int         cnt;
        logic       ful;
        logic       emp;
        logic       ovf;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic wr, input port_byte_t d, input logic rdy, input logic clr,
                       input logic vld, input port_byte_t td, input int cnt,
                       input logic ful, input logic emp, input logic ovf);
        vec_t v;
        v.wr = wr; v.d = d; v.rdy = rdy; v.clr = clr;
        v.vld = vld; v.td = td; v.cnt = cnt; v.ful = ful; v.emp = emp; v.ovf = ovf;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        port_byte_t q[$];
        int         drops;
        int         guard;
        logic       pop_m, full_m, rdy;

        rst = 1'b1; out_write = 1'b0; out_data = '0; tx_ready = 1'b0; ovf_clr = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h3C;
        #12;
        chk("rst.tx_valid", tx_valid, 1'b0);
        chk("rst.count",    count,    0);
        chk("rst.empty",    empty,    1'b1);
        chk("rst.full",     full,     1'b0);
        chk("rst.overflow", overflow, 1'b0);
        chk("rst.rx_ready", rx_ready, 1'b1);
`ifdef SCP_PORT_IN_LATCH_EN
        chk("rst.in_data",  in_data,  8'h00);
`else
        chk("rst.in_data",  in_data,  8'h3C);
`endif
        @(negedge clk);
        rst = 1'b0;
        step();

        // Directed table: single push/hold, fill, drop, full push+pop, drain, clear.
        add(1, 8'h7B, 0, 0, 1, 8'h7B, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) add(0, 8'h00, 0, 0, 1, 8'h7B, 1, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 0);
        for (int k = 1; k <= 8; k++)
            add(1, port_byte_t'(k), 0, 0, 1, 8'h01, k, (k == 8), 0, 0);
        add(1, 8'h09, 0, 1, 1, 8'h01, 8, 1, 0, 1);
        add(1, 8'hAA, 1, 0, 1, 8'h02, 8, 1, 0, 1);
        for (int k = 3; k <= 8; k++)
            add(0, 8'h00, 1, 0, 1, port_byte_t'(k), 10 - k, 0, 0, 1);
        add(0, 8'h00, 1, 0, 1, 8'hAA, 1, 0, 0, 1);
        add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 1);
        add(0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 1, 0);
        add(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 0);

        for (int i = 0; i < vt.size(); i++) begin
            out_write = vt[i].wr; out_data = vt[i].d; tx_ready = vt[i].rdy; ovf_clr = vt[i].clr;
            step();
            chk($sformatf("vec%0d.tx_valid", i), tx_valid, vt[i].vld);
            if (vt[i].vld) chk($sformatf("vec%0d.tx_data", i), tx_data, vt[i].td);
            chk($sformatf("vec%0d.count", i),    count,    vt[i].cnt);
            chk($sformatf("vec%0d.full", i),     full,     vt[i].ful);
            chk($sformatf("vec%0d.empty", i),    empty,    vt[i].emp);
            chk($sformatf("vec%0d.overflow", i), overflow, vt[i].ovf);
        end
        out_write = 1'b0; tx_ready = 1'b0; ovf_clr = 1'b0;

        // Continuous incrementing stream against a random sink, with a queue model.
        drops = 0;
        for (int i = 0; i < 200; i++) begin
            rdy = 1'($urandom_range(0, 1));
            out_write = 1'b1; out_data = port_byte_t'(i); tx_ready = rdy;
            chk("stream.tx_valid", tx_valid, (q.size() > 0));
            if (q.size() > 0) chk("stream.tx_data", tx_data, q[0]);
            chk("stream.count", count, q.size());
            full_m = (q.size() == DEPTH);
            pop_m  = (q.size() > 0) && rdy;
            if (pop_m) void'(q.pop_front());
            if (!full_m || pop_m) q.push_back(port_byte_t'(i));
            else drops++;
            step();
        end
        out_write = 1'b0; tx_ready = 1'b1;
        guard = 0;
        while (q.size() > 0 && guard < 50) begin
            chk("drain.tx_valid", tx_valid, 1'b1);
            chk("drain.tx_data", tx_data, q[0]);
            void'(q.pop_front());
            step();
            guard++;
        end
        chk("drain.empty",    empty,    1'b1);
        chk("drain.overflow", overflow, (drops > 0));
        tx_ready = 1'b0; ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("stream.ovf_clr", overflow, 1'b0);

        // Asynchronous reset mid-stream with three queued bytes.
        out_write = 1'b1;
        out_data = 8'h10; step();
        out_data = 8'h20; step();
        out_data = 8'h30; step();
        out_write = 1'b0;
        chk("pre_arst.count", count, 3);
        #3 rst = 1'b1;
        #1;
        chk("arst.tx_valid", tx_valid, 1'b0);
        chk("arst.count",    count,    0);
        chk("arst.empty",    empty,    1'b1);
        @(negedge clk);
        rst = 1'b0;
        step();
        out_write = 1'b1; out_data = 8'h55;
        step();
        out_write = 1'b0;
        chk("post_arst.tx_valid", tx_valid, 1'b1);
        chk("post_arst.tx_data",  tx_data,  8'h55);
        chk("post_arst.count",    count,    1);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk("post_arst.empty", empty, 1'b1);

        // Input port.
`ifdef SCP_PORT_IN_LATCH_EN
        rx_valid = 1'b1; rx_data = 8'hAA;
        step();
        chk("rx.in_data_latched", in_data,  8'hAA);
        chk("rx.ready_low",       rx_ready, 1'b0);
        rx_data = 8'h11;
        step();
        chk("rx.in_data_held", in_data,  8'hAA);
        chk("rx.ready_back",   rx_ready, 1'b1);
        rx_valid = 1'b0;
        step();
        chk("rx.in_data_idle", in_data,  8'hAA);
        chk("rx.ready_idle",   rx_ready, 1'b1);
`else
        rx_valid = 1'b1; rx_data = 8'hAA;
        #1;
        chk("rx.in_data_comb", in_data,  8'hAA);
        chk("rx.ready_tied",   rx_ready, 1'b1);
        rx_data = 8'h11;
        #1;
        chk("rx.in_data_follow", in_data, 8'h11);
        rx_valid = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
